// File: rtl/window_3x3.sv
// window_3x3: assembles a 3x3 pixel window from three line-delayed row streams,
// tagging each complete window with its centre coordinates and line/frame end flags.
module window_3x3 #(
  parameter int DATA_WIDTH   = 24,
  parameter int LINE_WIDTH   = 1920,
  parameter int FRAME_HEIGHT = 1080
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            i_ena,
  input  logic                            i_sof,
  input  logic [DATA_WIDTH-1:0]           i_row0,
  input  logic [DATA_WIDTH-1:0]           i_row1,
  input  logic [DATA_WIDTH-1:0]           i_row2,
  output logic                            o_valid,
  output logic [9*DATA_WIDTH-1:0]         o_win,
  output logic [$clog2(LINE_WIDTH)-1:0]   o_x,
  output logic [$clog2(FRAME_HEIGHT)-1:0] o_y,
  output logic                            o_eol,
  output logic                            o_eof
);
  localparam int XW = $clog2(LINE_WIDTH);
  localparam int YW = $clog2(FRAME_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);
  // The live input acts as tap0; only taps 1 and 2 need storage per row.
  logic [2:0][1:0][DATA_WIDTH-1:0] taps;
  logic [2:0][DATA_WIDTH-1:0]      rows;
  logic [9*DATA_WIDTH-1:0]         win;
  logic [XW-1:0]                   col, cur_col;
  logic [YW-1:0]                   row, cur_row;
  logic                            hit, last_col, last_row;
  assign rows = {i_row2, i_row1, i_row0};
  for (genvar r = 0; r < 3; r++) begin : g_row
    assign win[3*DATA_WIDTH*r +: 3*DATA_WIDTH] = {taps[r][1], taps[r][0], rows[r]};
  end
  // Start-of-frame overrides the counters for the sample it arrives with.
  always_comb begin
    cur_col  = i_sof ? '0 : col;
    cur_row  = i_sof ? '0 : row;
    hit      = (cur_col >= XW'(2)) && (cur_row >= YW'(2));
    last_col = cur_col == X_LAST;
    last_row = cur_row == Y_LAST;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      taps    <= '0;
      col     <= '0;
      row     <= '0;
      o_valid <= 1'b0;
      o_win   <= '0;
      o_x     <= '0;
      o_y     <= '0;
      o_eol   <= 1'b0;
      o_eof   <= 1'b0;
    end else begin
      o_valid <= i_ena && hit;
      o_eol   <= i_ena && hit && last_col;
      o_eof   <= i_ena && hit && last_col && last_row;
      if (i_ena) begin
        for (int i = 0; i < 3; i++) taps[i] <= {taps[i][0], rows[i]};
        col <= last_col ? '0 : cur_col + 1'b1;
        row <= last_col ? (last_row ? '0 : cur_row + 1'b1) : cur_row;
        if (hit) begin
          o_win <= win;
          o_x   <= cur_col - 1'b1;
          o_y   <= cur_row - 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_window_3x3.sv
// tb_window_3x3: scoreboard bench for window_3x3 at 8-bit pixels on a 4x4 frame.
module tb_window_3x3;
  localparam int DW = 8;
  typedef struct packed {
    logic [9*DW-1:0] win;
    logic [1:0]      x;
    logic [1:0]      y;
    logic            eol;
    logic            eof;
  } exp_t;
  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            i_ena = 1'b0;
  logic            i_sof = 1'b0;
  logic [DW-1:0]   i_row0 = '0, i_row1 = '0, i_row2 = '0;
  logic            o_valid, o_eol, o_eof;
  logic [9*DW-1:0] o_win;
  logic [1:0]      o_x, o_y;
  exp_t            q[$];
  int              total = 0, bad = 0;
  int              pulses = 0, eol_n = 0, eof_n = 0, p0 = 0;
  logic            gap = 1'b0, prev_v = 1'b0, cap_arm = 1'b0;
  logic [9*DW-1:0] last_win = '0, cap_win = '0;
  logic [1:0]      last_x = '0, last_y = '0, cap_x = '0, cap_y = '0;
  window_3x3 #(.DATA_WIDTH(DW), .LINE_WIDTH(4), .FRAME_HEIGHT(4)) dut (
    .clk(clk), .n_rst(n_rst), .i_ena(i_ena), .i_sof(i_sof),
    .i_row0(i_row0), .i_row1(i_row1), .i_row2(i_row2),
    .o_valid(o_valid), .o_win(o_win), .o_x(o_x), .o_y(o_y),
    .o_eol(o_eol), .o_eof(o_eof)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [9*DW-1:0] act, logic [9*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] pix(int ln, int c);
    return DW'(16 * ln + c);
  endfunction
  function automatic exp_t mk(int ln, int c);
    exp_t e;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) e.win[DW*(3*r+k) +: DW] = pix(ln - r, c - k);
    e.x = 2'(c - 1);
    e.y = 2'(ln - 1);
    e.eol = (c == 3);
    e.eof = (c == 3) && (ln == 3);
    return e;
  endfunction
  task automatic px(int ln, int c, bit sof);
    i_ena = 1'b1;
    i_sof = sof;
    i_row0 = pix(ln, c);
    i_row1 = pix(ln - 1, c);
    i_row2 = pix(ln - 2, c);
    if (c >= 2 && ln >= 2) q.push_back(mk(ln, c));
    @(posedge clk);
    #1;
    i_ena = 1'b0;
    i_sof = 1'b0;
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame(bit sof, int gaps);
    for (int ln = 0; ln < 4; ln++)
      for (int c = 0; c < 4; c++) begin
        px(ln, c, sof && ln == 0 && c == 0);
        if (gaps > 0) idle(gaps);
      end
  endtask
  // Expected hold values follow the reset to zero.
  always @(negedge n_rst) begin
    last_win = '0;
    last_x = '0;
    last_y = '0;
    prev_v = 1'b0;
  end
  always @(negedge clk) if (n_rst) begin
    if (o_valid) begin
      exp_t e;
      pulses++;
      if (o_eol) eol_n++;
      if (o_eof) eof_n++;
      if (cap_arm) begin
        cap_win = o_win;
        cap_x = o_x;
        cap_y = o_y;
        cap_arm = 1'b0;
      end
      if (gap) chk("no_back_to_back", 72'(prev_v), 72'(0));
      if (q.size() == 0) begin
        chk("unexpected_valid", 72'(1), 72'(0));
      end else begin
        e = q.pop_front();
        chk("win", o_win, e.win);
        chk("x", 72'(o_x), 72'(e.x));
        chk("y", 72'(o_y), 72'(e.y));
        chk("eol", 72'(o_eol), 72'(e.eol));
        chk("eof", 72'(o_eof), 72'(e.eof));
        last_win = e.win;
        last_x = e.x;
        last_y = e.y;
      end
    end else begin
      chk("idle_eol", 72'(o_eol), 72'(0));
      chk("idle_eof", 72'(o_eof), 72'(0));
      chk("hold_win", o_win, last_win);
      chk("hold_xy", 72'({o_x, o_y}), 72'({last_x, last_y}));
    end
    prev_v = o_valid;
  end
  initial begin
    idle(2);
    chk("rst_valid", 72'(o_valid), 72'(0));
    chk("rst_win", o_win, 72'(0));
    chk("rst_xy", 72'({o_x, o_y}), 72'(0));
    chk("rst_flags", 72'({o_eol, o_eof}), 72'(0));
    @(negedge clk);
    n_rst = 1'b1;
    idle(1);
    // continuous frame
    p0 = pulses;
    cap_arm = 1'b1;
    frame(1'b1, 0);
    idle(3);
    chk("frame_pulses", 72'(pulses - p0), 72'(4));
    chk("first_r0", 72'(cap_win[23:0]), 72'h202122);
    chk("first_r2", 72'(cap_win[71:48]), 72'h000102);
    chk("first_xy", 72'({cap_x, cap_y}), 72'({2'd1, 2'd1}));
    chk("eol_count", 72'(eol_n), 72'(2));
    chk("eof_count", 72'(eof_n), 72'(1));
    // gapped frame
    p0 = pulses;
    gap = 1'b1;
    frame(1'b1, 3);
    gap = 1'b0;
    idle(2);
    chk("gap_pulses", 72'(pulses - p0), 72'(4));
    // resync mid-frame at line 3 column 2
    for (int ln = 0; ln < 3; ln++)
      for (int c = 0; c < 4; c++) px(ln, c, 1'b0);
    px(3, 0, 1'b0);
    px(3, 1, 1'b0);
    p0 = pulses;
    px(0, 0, 1'b1);
    for (int k = 1; k < 10; k++) px(k / 4, k % 4, 1'b0);
    idle(2);
    chk("resync_10_accepts", 72'(pulses - p0), 72'(0));
    px(2, 2, 1'b0);
    idle(1);
    chk("resync_11th", 72'(pulses - p0), 72'(1));
    px(2, 3, 1'b0);
    for (int c = 0; c < 4; c++) px(3, c, 1'b0);
    idle(2);
    // async reset while a window is presented
    for (int k = 0; k < 11; k++) px(k / 4, k % 4, k == 0);
    chk("valid_pre_rst", 72'(o_valid), 72'(1));
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_valid", 72'(o_valid), 72'(0));
    chk("arst_win", o_win, 72'(0));
    chk("arst_xy", 72'({o_x, o_y}), 72'(0));
    chk("arst_flags", 72'({o_eol, o_eof}), 72'(0));
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    idle(1);
    p0 = pulses;
    for (int k = 0; k < 10; k++) px(k / 4, k % 4, 1'b0);
    idle(2);
    chk("post_rst_10_accepts", 72'(pulses - p0), 72'(0));
    px(2, 2, 1'b0);
    idle(1);
    chk("post_rst_11th", 72'(pulses - p0), 72'(1));
    px(2, 3, 1'b0);
    for (int c = 0; c < 4; c++) px(3, c, 1'b0);
    idle(2);
    // two frames back-to-back without start-of-frame
    p0 = pulses;
    eof_n = 0;
    frame(1'b0, 0);
    frame(1'b0, 0);
    idle(3);
    chk("wrap_pulses", 72'(pulses - p0), 72'(8));
    chk("wrap_eof", 72'(eof_n), 72'(2));
    chk("queue_empty", 72'(q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
